spi_slave_fsm: RTL and testbench
================================

# spi_slave_fsm

Control state machine for the SPI slave datapath. It consumes conditioned SPI strobes: chip-select level, plus one-cycle SCLK rising-edge and falling-edge pulses. It drives the enable and mode inputs of the 8-bit shift register, the address latch write enable, the data-memory write enable and the MISO tri-state buffer enable. Each transaction is ADDR_BITS address bits, then one R/W bit (1 = read), then DATA_BITS data bits, all MSB first, in SPI mode 0.

## Interface
- ADDR_BITS, 7, address bits shifted in before the R/W bit
- DATA_BITS, 8, data bits per transaction; must equal the shift register width
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- cs  in  1  conditioned chip select, active low (level, synchronous to clk)
- sclk_pos  in  1  one-clk pulse per SCLK rising edge
- sclk_neg  in  1  one-clk pulse per SCLK falling edge
- sr_lsb  in  1  shift register parallelOut[0]; holds the R/W bit after address phase
- sr_shift_en  out  1  drives shift register serialClk (update enable)
- sr_mode  out  2  shift register mode, shiftregmodes.v encoding: HOLD 00, RIGHT 01, LEFT 10, PLOAD 11
- addr_we  out  1  address latch write enable, one-cycle pulse
- dm_we  out  1  data memory write enable, one-cycle pulse
- miso_buff  out  1  MISO tri-state enable
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, GET_ADDR, LATCH_ADDR, READ_LOAD, READ_SHIFT, WRITE_RECV, WRITE_COMMIT, DONE.
- Bit counter is wide enough for max(ADDR_BITS+1, DATA_BITS). It clears on every state change.
- IDLE: cs=0 -> GET_ADDR.
- GET_ADDR: sr_mode=LEFT. On each sclk_pos, sr_shift_en=1 and the counter increments. The (ADDR_BITS+1)th pulse -> LATCH_ADDR.
- LATCH_ADDR: one cycle. addr_we=1 and sr_mode=HOLD. If sr_lsb=1 -> READ_LOAD, else -> WRITE_RECV.
- READ_LOAD: one cycle. sr_mode=PLOAD and sr_shift_en=1, which loads the memory read data for the latched address -> READ_SHIFT.
- READ_SHIFT: miso_buff=1 and sr_mode=LEFT; counts sclk_neg.
  - The 1st sclk_neg (end of the R/W bit) does not shift.
  - sclk_neg 2..DATA_BITS assert sr_shift_en.
  - The (DATA_BITS+1)th sclk_neg -> DONE with no shift.
- WRITE_RECV: sr_mode=LEFT. Each sclk_pos asserts sr_shift_en. The DATA_BITSth pulse -> WRITE_COMMIT.
- WRITE_COMMIT: one cycle. dm_we=1 -> DONE.
- DONE: all outputs inactive except busy. Waits for cs=1.
- Pulses on the wrong edge for the state (sclk_neg in GET_ADDR/WRITE_RECV, sclk_pos in READ_SHIFT) are ignored.
- cs=1 in any state:
  - sr_shift_en, addr_we, dm_we and miso_buff are forced to 0 combinationally in the same cycle.
  - The FSM goes to IDLE on the next edge.
  - cs takes priority over a simultaneous sclk pulse.
  - An aborted write never asserts dm_we.
- Outside the states listed above, sr_mode=HOLD.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, sr_shift_en=0, sr_mode=HOLD, addr_we=0, dm_we=0, miso_buff=0, busy=0. Reset mid-transaction aborts immediately with no dm_we.
- sr_shift_en is Mealy: it is high in the same clk cycle as the qualifying sclk pulse, so the shift register updates on that edge.
- addr_we, dm_we and PLOAD are state-decoded (Moore) and last exactly one clk.
- From the last address sclk_pos to miso_buff=1 is 3 clk: LATCH_ADDR, READ_LOAD, then READ_SHIFT.
- Half SCLK period must be >= 4 clk. The first read bit is then on MISO before the following sclk_neg.
- dm_we is asserted the cycle after the final data sclk_pos.

## Test plan
- Reset mid-GET_ADDR (after 3 sclk_pos) -> all outputs 0, busy=0 asynchronously; the next cs=0 restarts with counter 0.
- Write to address 0x2A, data 0xC3 (MOSI 0101010 0 11000011) -> exactly 16 sr_shift_en pulses. addr_we is high for one clk after the 8th. dm_we is high for one clk after the 16th. miso_buff stays 0.
- Read from address 0x05 (sr_lsb=1) -> addr_we, then PLOAD for 1 clk, then miso_buff=1. There are 7 sr_shift_en pulses across 9 sclk_neg. The 1st sclk_neg does not shift. The 9th sclk_neg -> DONE and miso_buff=0.
- cs rises after 4 write data bits -> dm_we never asserts; IDLE the next clk; busy=0.
- cs rises in the same cycle as an sclk_pos -> sr_shift_en=0 in that cycle.
- sclk_neg pulses during GET_ADDR and sclk_pos pulses during READ_SHIFT -> no sr_shift_en and no counter change.

Source files
------------

// File: rtl/spi_slave_fsm.sv
// Sequences the SPI slave datapath: address shift-in, R/W decode, read shift-out or write commit.
// Outputs are decoded from the current state; sr_shift_en also depends on the sclk pulses, and cs=1 forces all enables low.
module spi_slave_fsm #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       sclk_pos,
    input  logic       sclk_neg,
    input  logic       sr_lsb,
    output logic       sr_shift_en,
    output logic [1:0] sr_mode,
    output logic       addr_we,
    output logic       dm_we,
    output logic       miso_buff,
    output logic       busy
);

    localparam int CNT_MAX = (ADDR_BITS + 1 > DATA_BITS) ? ADDR_BITS + 1 : DATA_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(DATA_BITS - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_PLOAD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        LATCH_ADDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_RECV,
        WRITE_COMMIT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_shift_en = 1'b0;
        sr_mode     = MODE_HOLD;
        addr_we     = 1'b0;
        dm_we       = 1'b0;
        miso_buff   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cs) state_d = GET_ADDR;
            end
            GET_ADDR: begin
                sr_mode = MODE_LEFT;
                if (sclk_pos) begin
                    sr_shift_en = 1'b1;
                    if (cnt_q == ADDR_LAST) state_d = LATCH_ADDR;
                    else                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            LATCH_ADDR: begin
                addr_we = 1'b1;
                state_d = sr_lsb ? READ_LOAD : WRITE_RECV;
            end
            READ_LOAD: begin
                sr_mode     = MODE_PLOAD;
                sr_shift_en = 1'b1;
                state_d     = READ_SHIFT;
            end
            READ_SHIFT: begin
                miso_buff = 1'b1;
                sr_mode   = MODE_LEFT;
                // First falling edge only closes the R/W bit; the loaded MSB is already on MISO.
                if (sclk_neg) begin
                    if (cnt_q == RD_LAST) begin
                        state_d = DONE;
                    end else begin
                        sr_shift_en = (cnt_q != '0);
                        cnt_d       = cnt_q + CNT_ONE;
                    end
                end
            end
            WRITE_RECV: begin
                sr_mode = MODE_LEFT;
                if (sclk_pos) begin
                    sr_shift_en = 1'b1;
                    if (cnt_q == WR_LAST) state_d = WRITE_COMMIT;
                    else                  cnt_d   = cnt_q + CNT_ONE;
                end
            end
            WRITE_COMMIT: begin
                dm_we   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cs) begin
            state_d     = IDLE;
            sr_shift_en = 1'b0;
            addr_we     = 1'b0;
            dm_we       = 1'b0;
            miso_buff   = 1'b0;
        end

        if (state_d != state_q) cnt_d = '0;
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: inputs change just after negedge, outputs are sampled before the next posedge.
module tb_spi_slave_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic       sclk_pos;
    logic       sclk_neg;
    logic       sr_lsb;
    logic       sr_shift_en;
    logic [1:0] sr_mode;
    logic       addr_we;
    logic       dm_we;
    logic       miso_buff;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_sh   = 0;
    int n_awe  = 0;
    int n_dwe  = 0;
    int n_miso = 0;

    spi_slave_fsm #(.ADDR_BITS(7), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .sclk_pos   (sclk_pos),
        .sclk_neg   (sclk_neg),
        .sr_lsb     (sr_lsb),
        .sr_shift_en(sr_shift_en),
        .sr_mode    (sr_mode),
        .addr_we    (addr_we),
        .dm_we      (dm_we),
        .miso_buff  (miso_buff),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Running totals of enable cycles seen by the datapath at each active edge.
    always @(posedge clk) begin
        if (sr_shift_en) n_sh++;
        if (addr_we)     n_awe++;
        if (dm_we)       n_dwe++;
        if (miso_buff)   n_miso++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input logic p, input logic n);
        sclk_pos = p;
        sclk_neg = n;
        @(negedge clk);
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
    endtask

    // One SCLK period, 4 clk per half period.
    task automatic spi_bit();
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
    endtask

    // Seven address bits plus the R/W rising edge; returns with the FSM in LATCH_ADDR.
    task automatic send_addr(input logic rw);
        sr_lsb = rw;
        repeat (7) spi_bit();
        step(1'b1, 1'b0);
        check("addr_we_after_8th", addr_we, 1);
        check("latch_mode_hold", sr_mode, 0);
    endtask

    task automatic run_write();
        int sh0, a0, d0, m0;
        sh0 = n_sh; a0 = n_awe; d0 = n_dwe; m0 = n_miso;
        cs = 1'b0;
        step(1'b0, 1'b0);
        check("wr_busy_get_addr", busy, 1);
        check("wr_mode_left", sr_mode, 2);
        send_addr(1'b0);
        step(1'b0, 1'b0);
        check("wr_addr_we_one_clk", addr_we, 0);
        check("wr_recv_mode_left", sr_mode, 2);
        repeat (2) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        repeat (7) spi_bit();
        step(1'b1, 1'b0);
        check("wr_dm_we_after_16th", dm_we, 1);
        step(1'b0, 1'b0);
        check("wr_dm_we_one_clk", dm_we, 0);
        check("wr_done_busy", busy, 1);
        check("wr_done_mode_hold", sr_mode, 0);
        repeat (2) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        cs = 1'b1;
        step(1'b0, 1'b0);
        check("wr_idle_busy", busy, 0);
        check("wr_shift_count", n_sh - sh0, 16);
        check("wr_addr_we_count", n_awe - a0, 1);
        check("wr_dm_we_count", n_dwe - d0, 1);
        check("wr_miso_never", n_miso - m0, 0);
    endtask

    initial begin
        int sh1, d0;
        rst_n    = 1'b0;
        cs       = 1'b1;
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
        sr_lsb   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mode", sr_mode, 0);
        check("rst_shift_en", sr_shift_en, 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // Asynchronous reset after three address bits.
        cs = 1'b0;
        step(1'b0, 1'b0);
        repeat (3) spi_bit();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_mode", sr_mode, 0);
        check("midrst_outs", {sr_shift_en, addr_we, dm_we, miso_buff}, 0);
        cs = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // Write 0x2A <- 0xC3; addr_we timing also proves the counter restarted at 0.
        run_write();

        // Read from 0x05.
        cs = 1'b0;
        step(1'b0, 1'b0);
        send_addr(1'b1);
        step(1'b0, 1'b0);
        check("rd_pload_mode", sr_mode, 3);
        check("rd_pload_shift", sr_shift_en, 1);
        check("rd_pload_no_miso", miso_buff, 0);
        step(1'b0, 1'b0);
        check("rd_miso_on", miso_buff, 1);
        check("rd_shift_mode", sr_mode, 2);
        sh1 = n_sh;
        step(1'b0, 1'b0);
        sclk_neg = 1'b1;
        #1 check("rd_neg1_noshift", sr_shift_en, 0);
        @(negedge clk);
        sclk_neg = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        sclk_pos = 1'b1;
        #1 check("rd_pos_ignored", sr_shift_en, 0);
        @(negedge clk);
        sclk_pos = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        sclk_neg = 1'b1;
        #1 check("rd_neg2_shift", sr_shift_en, 1);
        @(negedge clk);
        sclk_neg = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        repeat (6) spi_bit();
        sclk_pos = 1'b1;
        #1 check("rd_pos9_ignored", sr_shift_en, 0);
        @(negedge clk);
        sclk_pos = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        sclk_neg = 1'b1;
        #1 check("rd_neg9_noshift", sr_shift_en, 0);
        @(negedge clk);
        sclk_neg = 1'b0;
        check("rd_done_miso_off", miso_buff, 0);
        check("rd_done_busy", busy, 1);
        check("rd_shift_count", n_sh - sh1, 7);
        cs = 1'b1;
        step(1'b0, 1'b0);
        check("rd_idle_busy", busy, 0);

        // Write aborted after four data bits.
        d0 = n_dwe;
        cs = 1'b0;
        step(1'b0, 1'b0);
        send_addr(1'b0);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        repeat (4) spi_bit();
        cs = 1'b1;
        #1 check("abort_still_busy", busy, 1);
        @(negedge clk);
        check("abort_idle", busy, 0);
        repeat (10) step(1'b0, 1'b0);
        check("abort_no_dm_we", n_dwe - d0, 0);

        // cs rising together with sclk_pos.
        cs = 1'b0;
        step(1'b0, 1'b0);
        sclk_pos = 1'b1;
        #1 check("pos_cs_low_shift", sr_shift_en, 1);
        @(negedge clk);
        sclk_pos = 1'b0;
        step(1'b0, 1'b0);
        cs = 1'b1;
        sclk_pos = 1'b1;
        #1 check("pos_cs_high_noshift", sr_shift_en, 0);
        @(negedge clk);
        sclk_pos = 1'b0;
        check("pos_cs_high_idle", busy, 0);
        step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
